apb_slv_memory_ws: RTL and testbench



---
 rtl/apb_slv_memory_ws.sv | 152 +++++++++++++++
 tb/tb_apb_slv_memory_ws.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slv_memory_ws.sv
// apb_slv_memory_ws: APB3 completer memory with byte strobes,
// fixed wait states, optional read-only upper region and PSLVERR.
module apb_slv_memory_ws #(
    parameter int DATA_SIZE   = 32,
    parameter int ADDR_SIZE   = 8,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_STATES = 1,
    parameter int RO_BASE     = MEM_DEPTH
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [ADDR_SIZE-1:0]   PADDR,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [DATA_SIZE-1:0]   PWDATA,
    input  logic [DATA_SIZE/8-1:0] PSTROBE,
    output logic                   PREADY,
    output logic [DATA_SIZE-1:0]   PRDATA,
    output logic                   PSLVERR
);

    localparam int NB = DATA_SIZE / 8;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] RO_L    = (ADDR_SIZE + 1)'(RO_BASE);
    localparam logic [CW-1:0]      WS_L    = CW'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           nxt_state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        nxt_cnt;

    logic [AW-1:0]        addr_q;
    logic                 write_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [NB-1:0]        strb_q;
    logic                 err_q;

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    logic                 setup;
    logic                 access;
    logic [ADDR_SIZE:0]   paddr_ext;
    logic                 req_err;
    logic                 in_idle;
    logic                 enter_done;
    logic [AW-1:0]        rd_idx;
    logic                 rd_err;
    logic                 rd_wr;

    assign setup     = PSEL & ~PENABLE;
    assign access    = PSEL & PENABLE;
    assign paddr_ext = {1'b0, PADDR};
    assign req_err   = (paddr_ext >= DEPTH_L) |
                       (PWRITE & (paddr_ext >= RO_L));

    // With zero wait states DONE is entered straight from the setup
    // cycle, so the live bus fields are used instead of the latches.
    assign in_idle    = (state == ST_IDLE);
    assign enter_done = (nxt_state == ST_DONE) && (state != ST_DONE);
    assign rd_idx     = in_idle ? PADDR[AW-1:0] : addr_q;
    assign rd_err     = in_idle ? req_err : err_q;
    assign rd_wr      = in_idle ? PWRITE : write_q;

    // Next-state and wait counter
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        nxt_state = ST_DONE;
                    end else begin
                        nxt_state = ST_WAIT;
                        nxt_cnt   = CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (access) begin
                    if (cnt == WS_L) begin
                        nxt_state = ST_DONE;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end else begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // State, request latches and registered bus outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (in_idle && setup) begin
                addr_q  <= PADDR[AW-1:0];
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTROBE;
                err_q   <= req_err;
            end
            PREADY  <= enter_done;
            PSLVERR <= enter_done & rd_err;
            if (enter_done && !rd_wr) begin
                PRDATA <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

    // Strobed write commit on the edge leaving DONE; contents not reset
    always_ff @(posedge PCLK) begin
        if (!PRESET && (state == ST_DONE) && write_q && !err_q) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slv_memory_ws.sv
// tb_apb_slv_memory_ws: directed bench for apb_slv_memory_ws with
// four instances (wait states 1, 0, 3, 15) on a shared bus.
module tb_apb_slv_memory_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  paddr;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrobe;
    logic        pready  [4];
    logic [31:0] prdata  [4];
    logic        pslverr [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        apb_slv_memory_ws #(
            .DATA_SIZE   (32),
            .ADDR_SIZE   (8),
            .MEM_DEPTH   (32),
            .WAIT_STATES (g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15),
            .RO_BASE     (g == 0 ? 28 : 32)
        ) u_dut (
            .PCLK    (clk),
            .PRESET  (rst),
            .PADDR   (paddr),
            .PSEL    (psel[g]),
            .PENABLE (penable),
            .PWRITE  (pwrite),
            .PWDATA  (pwdata),
            .PSTROBE (pstrobe),
            .PREADY  (pready[g]),
            .PRDATA  (prdata[g]),
            .PSLVERR (pslverr[g])
        );
    end

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          mode;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act,
                          input logic [31:0] bad);
        checks++;
        if (act === bad) begin
            failures++;
            $display("FAIL %s: got %h must differ from %h", nm, act, bad);
        end
    endtask

    // One full transfer on instance k; checks PREADY latency and width.
    task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er);
        int n;
        bit got;
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrobe = st;
        @(posedge clk);
        #1 penable = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (pready[k]) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk($sformatf("lat_u%0d_a%0d", k, a), n, ws_of(k));
        rd = prdata[k];
        er = pslverr[k];
        @(posedge clk);
        #1;
        psel    = '0;
        penable = 1'b0;
        chk($sformatf("ready_1cyc_u%0d", k), {31'b0, pready[k]}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] d5;
    logic [31:0] d31;
    bit          seen;

    initial begin
        vecs[0]  = '{1'b1, 8'd0,   32'h0000AAAA, 4'hF, 32'h0,        1'b0, 1};
        vecs[1]  = '{1'b1, 8'd3,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 1};
        vecs[2]  = '{1'b1, 8'd3,   32'h12345678, 4'h5, 32'h0,        1'b0, 1};
        vecs[3]  = '{1'b0, 8'd3,   32'h0,        4'h0, 32'hFF34FF78, 1'b0, 1};
        vecs[4]  = '{1'b1, 8'd3,   32'h00000000, 4'h0, 32'hFF34FF78, 1'b0, 1};
        vecs[5]  = '{1'b0, 8'd3,   32'h0,        4'h0, 32'hFF34FF78, 1'b0, 1};
        vecs[6]  = '{1'b0, 8'd40,  32'h0,        4'h0, 32'h0,        1'b1, 1};
        vecs[7]  = '{1'b1, 8'd32,  32'h00000077, 4'hF, 32'h0,        1'b1, 1};
        vecs[8]  = '{1'b0, 8'd0,   32'h0,        4'h0, 32'h0000AAAA, 1'b0, 1};
        vecs[9]  = '{1'b1, 8'd27,  32'hCAFE1234, 4'hF, 32'h0000AAAA, 1'b0, 1};
        vecs[10] = '{1'b1, 8'd27,  32'h0000BB00, 4'h2, 32'h0000AAAA, 1'b0, 1};
        vecs[11] = '{1'b0, 8'd27,  32'h0,        4'h0, 32'hCAFEBB34, 1'b0, 1};
        vecs[12] = '{1'b1, 8'd28,  32'h11111111, 4'hF, 32'hCAFEBB34, 1'b1, 1};
        vecs[13] = '{1'b0, 8'd255, 32'h0,        4'h0, 32'h0,        1'b1, 1};
        vecs[14] = '{1'b1, 8'd30,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b1, 1};
        vecs[15] = '{1'b0, 8'd30,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 2};
        vecs[16] = '{1'b0, 8'd31,  32'h0,        4'h0, 32'h0,        1'b0, 0};

        rst     = 1'b1;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrobe = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_pready_u%0d", k), {31'b0, pready[k]}, 32'd0);
            chk($sformatf("rst_pslverr_u%0d", k), {31'b0, pslverr[k]}, 32'd0);
            chk($sformatf("rst_prdata_u%0d", k), prdata[k], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            xfer(0, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st, rd, er);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (vecs[i].mode == 1) begin
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end else if (vecs[i].mode == 2) begin
                chk_ne($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end
        end

        for (int k = 1; k < 4; k++) begin
            d5  = 32'h5000_0000 | k;
            d31 = 32'h3100_0000 | k;
            xfer(k, 1'b1, 8'd5, d5, 4'hF, rd, er);
            chk($sformatf("sw%0d_w5_err", k), {31'b0, er}, 32'd0);
            xfer(k, 1'b1, 8'd31, d31, 4'hF, rd, er);
            chk($sformatf("sw%0d_w31_err", k), {31'b0, er}, 32'd0);
            xfer(k, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
            chk($sformatf("sw%0d_r5", k), rd, d5);
            xfer(k, 1'b0, 8'd31, 32'h0, 4'h0, rd, er);
            chk($sformatf("sw%0d_r31", k), rd, d31);
            xfer(k, 1'b0, 8'd32, 32'h0, 4'h0, rd, er);
            chk($sformatf("sw%0d_r32_err", k), {31'b0, er}, 32'd1);
            chk($sformatf("sw%0d_r32_data", k), rd, 32'd0);
            xfer(k, 1'b1, 8'd5, 32'hAB000000, 4'h8, rd, er);
            chk($sformatf("sw%0d_w5b_err", k), {31'b0, er}, 32'd0);
            xfer(k, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
            chk($sformatf("sw%0d_r5b", k), rd, {8'hAB, d5[23:0]});
        end

        psel    = 4'b0100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd5;
        pwdata  = 32'hDEADBEEF;
        pstrobe = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1;
        psel    = '0;
        penable = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (pready[2]) seen = 1'b1;
        end
        chk("abort_no_pready", {31'b0, seen}, 32'd0);
        xfer(2, 1'b0, 8'd5, 32'h0, 4'h0, rd, er);
        chk("abort_mem5", rd, 32'hAB000002);
        chk("abort_next_err", {31'b0, er}, 32'd0);

        xfer(0, 1'b0, 8'd3, 32'h0, 4'h0, rd, er);
        chk("pre_rst_read", rd, 32'hFF34FF78);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd0;
        pwdata  = 32'hDEADBEEF;
        pstrobe = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_pready", {31'b0, pready[0]}, 32'd0);
        chk("midrst_pslverr", {31'b0, pslverr[0]}, 32'd0);
        chk("midrst_prdata", prdata[0], 32'd0);
        psel    = '0;
        penable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_pready", {31'b0, pready[0]}, 32'd0);
        xfer(0, 1'b0, 8'd0, 32'h0, 4'h0, rd, er);
        chk("postrst_mem0", rd, 32'h0000AAAA);
        chk("postrst_err", {31'b0, er}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
